mips_mem_sys: RTL
=================

Name: mips_mem_sys

Overview:
Memory subsystem sitting directly downstream of the multicycle MIPS core. It serves the core's single unified instruction/data port (address, write data, mr, mw -> read_data) from a word-addressed RAM. It also decodes a small memory-mapped I/O window containing:
- a free-running cycle counter,
- a status register,
- an output FIFO that an external consumer drains through a valid/ready handshake.

Parameters:
RAM_WORDS, 1024, number of 32-bit RAM words; power of 2; RAM index = address_in[log2(RAM_WORDS)+1:2]
FIFO_DEPTH, 4, output FIFO entries; power of 2, >=2

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
address_in  input  32  byte address from core; bits [1:0] ignored (word access only)
write_data  input  32  store data from core
mr  input  1  memory read enable
mw  input  1  memory write enable
read_data  output  32  read data to core, combinational from address_in/mr
out_data  output  32  FIFO head word
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head when out_valid & out_ready
bus_error  output  1  sticky: unmapped access seen

Behaviour:
- Address map (word-aligned, [1:0] ignored):
  - RAM: address_in[31:16]==16'h0000 and word index < RAM_WORDS. Aliasing above RAM_WORDS inside 0x0000xxxx counts as unmapped.
  - 0xFFFF0000 CYCLE: read returns counter. Counter is 32-bit, +1 every cycle, wraps 0xFFFFFFFF->0. A write loads 0 at that edge; the counter counts from 0 on the following cycles.
  - 0xFFFF0004 TXDATA: write pushes write_data into FIFO. Read returns 0.
  - 0xFFFF0008 STATUS: read = {29'b0, overflow, full, empty}. Writes ignored except bit 2=1, which clears overflow.
  - All other addresses are unmapped. Read returns 32'h0. Any mr or mw sets bus_error.
- Reads are combinational. read_data = selected value when mr=1, else 32'h0. The core latches it at the next edge (IR/MDR), so there is no added latency.
- RAM write: on a rising edge with mw=1 and a RAM-region address, mem[idx] <= write_data. Read-during-write to the same word returns the old value in that cycle.
- mr and mw both high: the write is performed and read_data shows the pre-write value. Not an error.
- FIFO:
  - Circular buffer with read/write pointers plus count (0..FIFO_DEPTH).
  - Pop = out_valid & out_ready. Push = mw to TXDATA.
  - A pop is evaluated before a push in the same cycle. Full + pop + push: both occur and count is unchanged.
  - Push while full with no pop: data dropped, overflow set (sticky), count unchanged.
  - Empty + push: no bypass. out_valid rises the cycle after the push edge.
  - out_data = buffer[rd_ptr]. It holds stable while out_valid=1 and out_ready=0. Pointers wrap modulo FIFO_DEPTH.
  - full = (count==FIFO_DEPTH), empty = (count==0).
- Reset (rst=1 at edge):
  - Clears: cycle counter=0, FIFO pointers/count=0 (out_valid=0), overflow=0, bus_error=0.
  - RAM contents are not cleared. Benches preload RAM by hierarchical $readmemh.
  - Reset mid-stream discards queued FIFO words.
  - read_data stays combinational; it reads 0 for MMIO counters immediately after reset.
- bus_error clears only on rst.

Test Plan:
1. RAM: write 0xDEADBEEF to 0x00000010 with mw=1, then mr=1 at 0x00000010 -> read_data=0xDEADBEEF. A read of 0x00000013 returns the same word.
2. Cycle counter: 5 cycles after reset release, read 0xFFFF0000 -> 5. Write at a cycle, read 3 cycles later -> 2. Force counter to 0xFFFFFFFF via hierarchical write -> next value 0.
3. FIFO flow: push 0x11,0x22,0x33 with out_ready=0 -> STATUS=0, out_data=0x11 held. Raise out_ready for 3 cycles -> out_data sequence 0x11,0x22,0x33, then out_valid=0 and STATUS=1.
4. FIFO overflow: push 5 words with FIFO_DEPTH=4, out_ready=0 -> 5th dropped, STATUS=0b110. Write STATUS 0x4 -> STATUS=0b010. With full FIFO, push+pop same cycle -> count stays 4 and the new word appears last.
5. Unmapped: mr=1 at 0x12340000 -> read_data=0, bus_error=1 next cycle and stays 1 until rst. mr=0 at any address -> read_data=0.
6. Reset mid-operation: 3 words queued, counter=100, assert rst one cycle -> out_valid=0, CYCLE reads 0, RAM word from scenario 1 still reads 0xDEADBEEF.

Source files
------------

// File: rtl/mips_mem_sys.sv
// Memory subsystem behind the multicycle MIPS core: word-addressed RAM plus an MMIO
// window holding a cycle counter, a status register and an output FIFO.
module mips_mem_sys #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address_in,
    input  logic [31:0] write_data,
    input  logic        mr,
    input  logic        mw,
    output logic [31:0] read_data,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        bus_error
);
    localparam int IDX_W = $clog2(RAM_WORDS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Word addresses (byte address >> 2) of the MMIO registers
    localparam logic [29:0] CYC_WA = 30'h3FFF_C000;
    localparam logic [29:0] TX_WA  = 30'h3FFF_C001;
    localparam logic [29:0] ST_WA  = 30'h3FFF_C002;

    logic [31:0]      mem [RAM_WORDS];
    logic [31:0]      fifo_mem [FIFO_DEPTH];

    logic [31:0]      cycle_q, cycle_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             bus_error_q, bus_error_d;

    logic [13:0]      word_addr_s;
    logic [IDX_W-1:0] ram_idx_s;
    logic             sel_ram_s, sel_cyc_s, sel_tx_s, sel_st_s, unmapped_s;
    logic             full_s, empty_s, pop_s, push_req_s, push_ok_s;
    logic             ram_we_s, cyc_we_s, st_clr_s;
    logic [31:0]      status_s;
    logic             unused_s;

    assign unused_s    = ^address_in[1:0];
    assign word_addr_s = address_in[15:2];
    assign ram_idx_s   = address_in[IDX_W+1:2];

    // Addresses in 0x0000xxxx beyond the RAM size fall through to unmapped
    assign sel_ram_s  = (address_in[31:16] == 16'h0000) && ((word_addr_s >> IDX_W) == 14'd0);
    assign sel_cyc_s  = (address_in[31:2] == CYC_WA);
    assign sel_tx_s   = (address_in[31:2] == TX_WA);
    assign sel_st_s   = (address_in[31:2] == ST_WA);
    assign unmapped_s = ~(sel_ram_s | sel_cyc_s | sel_tx_s | sel_st_s);

    assign full_s     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_s    = (count_q == CNT_W'(0));
    assign pop_s      = ~empty_s & out_ready;
    assign push_req_s = mw & sel_tx_s;
    assign push_ok_s  = push_req_s & (~full_s | pop_s);
    assign ram_we_s   = mw & sel_ram_s;
    assign cyc_we_s   = mw & sel_cyc_s;
    assign st_clr_s   = mw & sel_st_s & write_data[2];
    assign status_s   = {29'd0, overflow_q, full_s, empty_s};

    assign out_data  = fifo_mem[rd_ptr_q];
    assign out_valid = ~empty_s;
    assign bus_error = bus_error_q;

    // Combinational read mux; RAM read sees the pre-write contents
    always_comb begin
        read_data = 32'd0;
        if (mr) begin
            if (sel_ram_s) begin
                read_data = mem[ram_idx_s];
            end else if (sel_cyc_s) begin
                read_data = cycle_q;
            end else if (sel_st_s) begin
                read_data = status_s;
            end else begin
                read_data = 32'd0;
            end
        end else begin
            read_data = 32'd0;
        end
    end

    // Next-state logic for counter, FIFO bookkeeping and sticky flags
    always_comb begin
        cycle_d     = cycle_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        bus_error_d = bus_error_q | ((mr | mw) & unmapped_s);

        if (cyc_we_s) begin
            cycle_d = 32'd0;
        end else begin
            cycle_d = cycle_q + 32'd1;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (st_clr_s) begin
            overflow_d = 1'b0;
        end else if (push_req_s & ~push_ok_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control and status state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q     <= 32'd0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            cycle_q     <= cycle_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            bus_error_q <= bus_error_d;
        end
    end

    // RAM storage is never reset so preloaded images survive rst
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem[ram_idx_s] <= write_data;
        end
    end

    // FIFO storage; when full with a pop, the freed head slot takes the new word
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_mem[wr_ptr_q] <= write_data;
        end
    end

endmodule
